// File: rtl/mem_load_unit_if.sv
// Request, memory-read and response signals between the load unit and its neighbours.
// The slave modport is the load unit; the master modport is the pipeline/memory side.
interface mem_load_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        rom_re;
    logic        ram_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_read_valid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_addr, req_funct3, req_rd, mem_rdata, mem_read_valid, rsp_ready,
        output req_ready, rom_re, ram_re, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_funct3, req_rd, mem_rdata, mem_read_valid, rsp_ready,
        input  req_ready, rom_re, ram_re, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err
    );
endinterface

// File: rtl/mem_load_unit.sv
// Load request controller: decodes ROM/RAM target, pulses the read enable, extends the result.
// Optional WAIT timeout enabled by defining LOAD_UNIT_TIMEOUT_EN.
module mem_load_unit #(
    parameter logic [31:0] ROM_LIMIT      = 32'h0000_FFFF,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    mem_load_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, stateNext;
    logic [1:0]  laneQ;
    logic [2:0]  funct3Q;
    logic        romSelQ;
    logic        firstWaitQ;
    logic [31:0] memAddrQ;
    logic [31:0] rspDataQ;
    logic [4:0]  rspRdQ;
    logic        rspErrQ;
    logic        reqLegal;
    logic        timeoutHit;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h00_0000, b};
            3'b101:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        case (bus.req_funct3)
            3'b000, 3'b100: reqLegal = 1'b1;
            3'b001, 3'b101: reqLegal = ~bus.req_addr[0];
            3'b010:         reqLegal = (bus.req_addr[1:0] == 2'b00);
            default:        reqLegal = 1'b0;
        endcase
    end

`ifdef LOAD_UNIT_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] waitCnt;

    // Cleared while idle so it is zero on every entry to WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            waitCnt <= '0;
        else if (state == IDLE)
            waitCnt <= '0;
        else if (state == WAIT && !bus.mem_read_valid)
            waitCnt <= waitCnt + 1'b1;
    end

    assign timeoutHit = (state == WAIT) && !bus.mem_read_valid && (waitCnt == TO_LAST);
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.req_valid) stateNext = reqLegal ? WAIT : RESP;
            WAIT:    if (bus.mem_read_valid || timeoutHit) stateNext = RESP;
            RESP:    if (bus.rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            laneQ      <= '0;
            funct3Q    <= '0;
            romSelQ    <= 1'b0;
            firstWaitQ <= 1'b0;
            memAddrQ   <= '0;
            rspDataQ   <= '0;
            rspRdQ     <= '0;
            rspErrQ    <= 1'b0;
        end else begin
            firstWaitQ <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    laneQ   <= bus.req_addr[1:0];
                    funct3Q <= bus.req_funct3;
                    rspRdQ  <= bus.req_rd;
                    if (reqLegal) begin
                        memAddrQ   <= {bus.req_addr[31:2], 2'b00};
                        romSelQ    <= (bus.req_addr <= ROM_LIMIT);
                        firstWaitQ <= 1'b1;
                    end else begin
                        rspDataQ <= '0;
                        rspErrQ  <= 1'b1;
                    end
                end
                WAIT: if (bus.mem_read_valid) begin
                    rspDataQ <= extract(bus.mem_rdata, laneQ, funct3Q);
                    rspErrQ  <= 1'b0;
                end else if (timeoutHit) begin
                    rspDataQ <= '0;
                    rspErrQ  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Enables derive from registered state so reset drops them without waiting for a clock.
    assign bus.req_ready = (state == IDLE);
    assign bus.rom_re    = (state == WAIT) && firstWaitQ && romSelQ;
    assign bus.ram_re    = (state == WAIT) && firstWaitQ && !romSelQ;
    assign bus.mem_addr  = memAddrQ;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rspDataQ;
    assign bus.rsp_rd    = rspRdQ;
    assign bus.rsp_err   = rspErrQ;
endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Load/fetch request controller sitting directly upstream of the ROM/RAM read-data mux. It accepts one read request at a time from the pipeline and decodes the target (ROM at addresses up to `ROM_LIMIT`, RAM above). It pulses the matching memory read enable and waits for the mux's merged read-valid. It then aligns and sign-/zero-extends the muxed word and returns it with a valid/ready handshake. Misaligned or illegal requests, and (optionally) timeouts, return an error without stalling forever.

## Interface
- `ROM_LIMIT`, default 32'h0000_FFFF: highest ROM byte address. `addr <= ROM_LIMIT` selects ROM.
- `TIMEOUT_CYCLES`, default 64: maximum number of WAIT cycles before a timeout error. Minimum 2.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request. High only in IDLE.
- `req_addr` in 32: byte address.
- `req_funct3` in 3: load type; 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `req_rd` in 5: destination tag, returned unchanged.
- `rom_re` out 1: ROM read-enable pulse.
- `ram_re` out 1: RAM read-enable pulse.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_rdata` in 32: muxed read data.
- `mem_read_valid` in 1: muxed read-valid.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out 32: extended load result.
- `rsp_rd` out 5: tag of the request.
- `rsp_err` out 1: request was misaligned, had an illegal funct3, or timed out.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch addr[1:0], funct3 and rd.
  - Legal, aligned request: drive `mem_addr`, go to WAIT.
  - Illegal funct3 (011/110/111), halfword with addr[0]=1, or word with addr[1:0]≠0: go to RESP with `rsp_err`=1 and `rsp_data`=0. No memory enable is issued.
- WAIT:
  - `rom_re` (addr ≤ ROM_LIMIT) or `ram_re` (otherwise) is high in the first WAIT cycle only.
  - `mem_addr` is held stable for the whole of WAIT.
  - When `mem_read_valid`=1, capture the extended data and go to RESP with `rsp_err`=0.
- RESP:
  - `rsp_valid`=1; `rsp_data`, `rsp_rd` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE.
- Extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend to 32 bits. LBU/LHU zero-extend. LW passes the word through unchanged.
- `mem_read_valid` is ignored outside WAIT.
- `rom_re` and `ram_re` are never high together.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `rom_re`=`ram_re`=0, `mem_addr`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_rd`=0, `rsp_err`=0, timeout counter=0.
- Request accepted at edge N:
  - Cycle N+1 is WAIT with the enable high.
  - `mem_read_valid` is sampled starting in cycle N+1 (a combinational memory may answer in that cycle).
  - Earliest `rsp_valid` is cycle N+2.
- Error requests: accepted at edge N, `rsp_valid` in cycle N+1.
- Back-to-back throughput: `req_ready` returns in the cycle after the `rsp_ready` handshake, so the maximum rate is one request per 3 cycles.
- Reset asserted mid-WAIT or mid-RESP: return to IDLE immediately. Any in-flight response is discarded and enables drop asynchronously.

## Configuration
- `LOAD_UNIT_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without `mem_read_valid`.
  - When it reaches `TIMEOUT_CYCLES`-1 with no valid, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - If valid and the timeout occur in the same cycle, valid wins.
- `LOAD_UNIT_TIMEOUT_EN` undefined: no counter; WAIT persists until `mem_read_valid`. `rsp_err` comes only from decode errors.

## Test plan
- LW at 0x0000_0100, `mem_rdata`=0xDEADBEEF, valid in the first WAIT cycle -> `rom_re` pulses exactly 1 cycle; `rsp_valid` two cycles after accept; `rsp_data`=0xDEADBEEF, `rsp_err`=0.
- LB at 0x0001_0003, rdata=0x80FF_FFFF, valid after 3 cycles -> `ram_re` only; `rsp_data`=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- LH at 0x0000_0002 and LHU at 0x0000_0002, rdata=0x8001_1234 -> 0xFFFF_8001 and 0x0000_8001. Boundary: address 0x0000_FFFC selects ROM, 0x0001_0000 selects RAM.
- LW at 0x0000_0006, then funct3=011 -> no enable; `rsp_err`=1 and `rsp_data`=0 one cycle after accept.
- Hold `rsp_ready`=0 for 5 cycles -> `rsp_*` stable and `req_ready`=0 throughout. Assert `rst` during WAIT -> all outputs return to reset values with no response.
- With `LOAD_UNIT_TIMEOUT_EN` and TIMEOUT_CYCLES=4, never assert valid -> `rsp_err`=1 after 4 WAIT cycles. Valid on the 4th cycle -> normal response with `rsp_err`=0.
